lissajous_sweep_ctrl: RTL and testbench
=======================================

LISSAJOUS_SWEEP_CTRL -- requirements
Module: lissajous_sweep_ctrl

Interface
REQ-001 Parameter PHASE_MOD, default 360: phase-word modulus (degrees).
REQ-002 Parameter F2_MIN, default 1: lowest Fword2 in ratio sweep.
REQ-003 Parameter F2_MAX, default 255: highest Fword2 in ratio sweep.
REQ-004 Parameter RST_CYC, default 2: DDS_rst pulse length in clk cycles (1..15).
REQ-005 clk  in  1  DDS sample clock; single clock domain.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  begin sweep (level sampled each clk).
REQ-008 stop  in  1  end sweep; wins over start.
REQ-009 mode  in  1  0 = phase sweep of Pword2, 1 = ratio sweep of Fword2; sampled only on start.
REQ-010 dwell  in  16  clk cycles held per sweep step; 0 treated as 1.
REQ-011 pstep  in  9  phase increment; values > PHASE_MOD-1 clamped to PHASE_MOD-1.
REQ-012 man_load  in  1  load manual words (IDLE only).
REQ-013 man_F1 / man_F2 / man_P2  in  6 / 8 / 9  manual Fword1, Fword2, Pword2.
REQ-014 Fword1 / Fword2 / Pword1 / Pword2  out  6 / 8 / 9 / 9  registered DDS configuration words.
REQ-015 DDS_rst  out  1  active-high DDS phase-accumulator resync pulse.
REQ-016 sweeping  out  1  high in DWELL, UPDATE, RESYNC while a sweep is active.
REQ-017 step_pulse  out  1  one-cycle strobe in the UPDATE cycle.

Function
REQ-018 FSM states IDLE, DWELL, UPDATE, RESYNC; encoding free.
REQ-019 IDLE: stop -> IDLE; start & !stop -> DWELL, dwell counter cleared, mode latched; else man_load -> RESYNC (manual path).
REQ-020 Manual path: on man_load cycle register Fword1<=man_F1, Fword2<=man_F2, Pword2<=man_P2 mod PHASE_MOD (one conditional subtract); Pword1 stays 0; RESYNC then back to IDLE.
REQ-021 man_load outside IDLE is ignored.
REQ-022 DWELL: counter increments each cycle; when counter == max(dwell,1)-1 -> UPDATE next cycle; stop -> IDLE next cycle, words unchanged.
REQ-023 UPDATE (exactly one cycle): mode 0: Pword2 <= (Pword2 + pstep_clamped) with subtract PHASE_MOD if sum >= PHASE_MOD, 10-bit intermediate; mode 1: Fword2 <= Fword2+1, wraps to F2_MIN when Fword2 >= F2_MAX; Fword2 < F2_MIN on entry loads F2_MIN.
REQ-024 UPDATE -> RESYNC unconditionally.
REQ-025 RESYNC: DDS_rst high for exactly RST_CYC cycles starting the cycle after the word change; then DWELL with counter cleared, or IDLE if stop was seen at any point in UPDATE/RESYNC (stop latched, not lost).
REQ-026 Word outputs change only in UPDATE or on man_load; stable during DWELL and RESYNC.
REQ-027 Step period in sweep = max(dwell,1) + 1 + RST_CYC cycles.
REQ-028 Inputs dwell, pstep sampled live each step; change mid-DWELL takes effect on the current count comparison.

Reset
REQ-029 While reset high: state IDLE, Fword1=1, Fword2=1, Pword1=0, Pword2=0, DDS_rst=0, sweeping=0, step_pulse=0, counters and stop latch 0.
REQ-030 Reset asserted mid-sweep or mid-RESYNC aborts immediately to reset values; DDS_rst drops asynchronously.

Verification
REQ-031 Reset then man_load with man_F1=3, man_F2=2, man_P2=90 -> words 3/2/0/90 next cycle, DDS_rst high 2 cycles, back to IDLE.
REQ-032 mode=0, pstep=90, dwell=4, Pword2=0, start -> Pword2 sequence 90,180,270,0 every 7 cycles, step_pulse each update, DDS_rst 2 cycles after each.
REQ-033 mode=0, pstep=500, Pword2=300 -> next Pword2 = 299 (clamp 359, 659-360).
REQ-034 mode=1, Fword2=254, F2_MAX=255 -> 255 then 1 (wrap to F2_MIN).
REQ-035 start and stop both high in IDLE -> stays IDLE; stop asserted in the UPDATE cycle -> RESYNC completes 2 cycles, then IDLE, sweeping low.
REQ-036 dwell=0 -> behaves as dwell=1, step period 4 cycles; reset pulsed during RESYNC -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/lissajous_sweep_ctrl.sv
// Sweep controller for a two-channel DDS Lissajous generator: steps Pword2 (phase)
// or Fword2 (ratio) after each dwell and pulses DDS_rst so both accumulators resync.
module lissajous_sweep_ctrl #(
  parameter int PHASE_MOD = 360,
  parameter int F2_MIN    = 1,
  parameter int F2_MAX    = 255,
  parameter int RST_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  input  logic [15:0] dwell,
  input  logic [8:0]  pstep,
  input  logic        man_load,
  input  logic [5:0]  man_F1,
  input  logic [7:0]  man_F2,
  input  logic [8:0]  man_P2,
  output logic [5:0]  Fword1,
  output logic [7:0]  Fword2,
  output logic [8:0]  Pword1,
  output logic [8:0]  Pword2,
  output logic        DDS_rst,
  output logic        sweeping,
  output logic        step_pulse
);

  localparam logic [9:0] LP_MOD      = 10'(PHASE_MOD);
  localparam logic [8:0] LP_PMAX     = 9'(PHASE_MOD - 1);
  localparam logic [7:0] LP_F2_MIN   = 8'(F2_MIN);
  localparam logic [7:0] LP_F2_MAX   = 8'(F2_MAX);
  localparam logic [3:0] LP_RST_LAST = 4'(RST_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_UPDATE, S_RESYNC} state_t;

  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic [3:0]  r_rcnt;
  logic        r_stop_lat, r_mode, r_manual;
  logic [5:0]  r_fword1;
  logic [7:0]  r_fword2;
  logic [8:0]  r_pword2;

  logic [15:0] w_dwell_last;
  logic        w_rs_done;
  logic [8:0]  w_pstep_c, w_pnext, w_man_p2;
  logic [9:0]  w_psum, w_man_ext;
  logic [7:0]  w_f2_next;

  assign w_dwell_last = (dwell == 16'd0) ? 16'd0 : dwell - 16'd1;
  assign w_rs_done    = (r_rcnt == LP_RST_LAST);

  assign w_pstep_c = (pstep > LP_PMAX) ? LP_PMAX : pstep;
  assign w_psum    = {1'b0, r_pword2} + {1'b0, w_pstep_c};
  assign w_pnext   = (w_psum >= LP_MOD) ? 9'(w_psum - LP_MOD) : w_psum[8:0];
  assign w_man_ext = {1'b0, man_P2};
  assign w_man_p2  = (w_man_ext >= LP_MOD) ? 9'(w_man_ext - LP_MOD) : man_P2;
  // Out-of-range ratio words (below min or at max) restart the sweep at F2_MIN.
  assign w_f2_next = (r_fword2 < LP_F2_MIN || r_fword2 >= LP_F2_MAX) ? LP_F2_MIN
                                                                     : r_fword2 + 8'd1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (stop)          w_next = S_IDLE;
        else if (start)    w_next = S_DWELL;
        else if (man_load) w_next = S_RESYNC;
      end
      S_DWELL: begin
        // >= rather than == so a dwell shortened mid-count still terminates.
        if (stop)                       w_next = S_IDLE;
        else if (r_cnt >= w_dwell_last) w_next = S_UPDATE;
      end
      S_UPDATE: w_next = S_RESYNC;
      S_RESYNC: begin
        if (w_rs_done)
          w_next = (r_manual || r_stop_lat || stop) ? S_IDLE : S_DWELL;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rcnt     <= '0;
      r_stop_lat <= 1'b0;
      r_mode     <= 1'b0;
      r_manual   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_DWELL && w_next == S_DWELL) ? r_cnt + 16'd1 : 16'd0;
      r_rcnt  <= (r_state == S_RESYNC && !w_rs_done) ? r_rcnt + 4'd1 : 4'd0;
      if ((r_state == S_UPDATE || r_state == S_RESYNC) && stop)
        r_stop_lat <= 1'b1;
      else if (r_state == S_IDLE || r_state == S_DWELL)
        r_stop_lat <= 1'b0;
      if (r_state == S_IDLE) begin
        r_manual <= (w_next == S_RESYNC);
        if (w_next == S_DWELL) r_mode <= mode;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fword1 <= 6'd1;
      r_fword2 <= 8'd1;
      r_pword2 <= 9'd0;
    end else if (r_state == S_IDLE && w_next == S_RESYNC) begin
      r_fword1 <= man_F1;
      r_fword2 <= man_F2;
      r_pword2 <= w_man_p2;
    end else if (r_state == S_UPDATE) begin
      if (r_mode) r_fword2 <= w_f2_next;
      else        r_pword2 <= w_pnext;
    end
  end

  assign Fword1     = r_fword1;
  assign Fword2     = r_fword2;
  assign Pword1     = '0;
  assign Pword2     = r_pword2;
  assign DDS_rst    = (r_state == S_RESYNC);
  assign sweeping   = (r_state != S_IDLE) && !r_manual;
  assign step_pulse = (r_state == S_UPDATE);

endmodule

// File: tb/tb_lissajous_sweep_ctrl.sv
// Self-checking bench for lissajous_sweep_ctrl: outputs are predicted per cycle from
// the step-period arithmetic and word update rules, not from the FSM structure.
module tb_lissajous_sweep_ctrl;
  localparam int PM = 360, FMIN = 1, FMAX = 255, RC = 2;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic        man_load = 1'b0;
  logic [15:0] dwell = '0;
  logic [8:0]  pstep = '0, man_P2 = '0;
  logic [5:0]  man_F1 = '0;
  logic [7:0]  man_F2 = '0;
  logic [5:0]  Fword1;
  logic [7:0]  Fword2;
  logic [8:0]  Pword1, Pword2;
  logic        DDS_rst, sweeping, step_pulse;

  int n_checks = 0, n_err = 0;
  int ef1 = 1, ef2 = 1, ep2 = 0;

  lissajous_sweep_ctrl #(.PHASE_MOD(PM), .F2_MIN(FMIN), .F2_MAX(FMAX), .RST_CYC(RC)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode), .dwell(dwell),
    .pstep(pstep), .man_load(man_load), .man_F1(man_F1), .man_F2(man_F2), .man_P2(man_P2),
    .Fword1(Fword1), .Fword2(Fword2), .Pword1(Pword1), .Pword2(Pword2),
    .DDS_rst(DDS_rst), .sweeping(sweeping), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int f1, input int f2, input int p2,
                         input int rs, input int sw, input int pl);
    chk({tag, ".Fword1"},     16'(Fword1),     16'(f1));
    chk({tag, ".Fword2"},     16'(Fword2),     16'(f2));
    chk({tag, ".Pword1"},     16'(Pword1),     16'd0);
    chk({tag, ".Pword2"},     16'(Pword2),     16'(p2));
    chk({tag, ".DDS_rst"},    16'(DDS_rst),    16'(rs));
    chk({tag, ".sweeping"},   16'(sweeping),   16'(sw));
    chk({tag, ".step_pulse"}, 16'(step_pulse), 16'(pl));
  endtask

  function automatic int f2_after(input int f0, input int k);
    int f = f0;
    for (int i = 0; i < k; i++) f = (f < FMIN || f >= FMAX) ? FMIN : f + 1;
    return f;
  endfunction

  // Manual load from IDLE; called and returns just after a negedge.
  task automatic man(input int f1, input int f2, input int p2);
    man_F1 = 6'(f1); man_F2 = 8'(f2); man_P2 = 9'(p2); man_load = 1'b1;
    @(negedge clk);
    man_load = 1'b0;
    ef1 = f1; ef2 = f2; ep2 = p2 % PM;
    for (int i = 0; i < RC; i++) begin
      chk_out($sformatf("man rs%0d", i), ef1, ef2, ep2, 1, 0, 0);
      @(negedge clk);
    end
    chk_out("man done", ef1, ef2, ep2, 0, 0, 0);
  endtask

  // Start a sweep, pulse stop for one cycle at cycle sn, and check every cycle
  // until two cycles after the controller is expected back in IDLE.
  task automatic sweep(input int md, input int dw, input int ps, input int sn, input int mload);
    int d = (dw == 0) ? 1 : dw;
    int p = d + 1 + RC;
    int c = (ps > PM - 1) ? PM - 1 : ps;
    int ph = sn % p;
    int idle_n = (ph < d) ? sn + 1 : sn - ph + p;
    int k, kn, rs, sw, pl, f2e, p2e;
    start = 1'b1; mode = (md != 0); dwell = 16'(dw); pstep = 9'(ps);
    for (int n = 0; n <= idle_n + 1; n++) begin
      @(negedge clk);
      if (n == 0) begin start = 1'b0; mode = ~mode; end
      kn = (n < idle_n) ? n : idle_n - 1;
      k  = (kn >= d + 1) ? (kn - d - 1) / p + 1 : 0;
      if (n < idle_n) begin
        sw = 1; pl = (n % p == d) ? 1 : 0; rs = (n % p > d) ? 1 : 0;
      end else begin
        sw = 0; pl = 0; rs = 0;
      end
      f2e = (md != 0) ? f2_after(ef2, k) : ef2;
      p2e = (md != 0) ? ep2 : (ep2 + k * c) % PM;
      chk_out($sformatf("sweep m%0d d%0d p%0d n%0d", md, dw, ps, n), ef1, f2e, p2e, rs, sw, pl);
      man_load = (mload != 0 && n < sn);
      man_F1 = 6'($urandom); man_F2 = 8'($urandom); man_P2 = 9'($urandom);
      stop = (n == sn);
    end
    stop = 1'b0; man_load = 1'b0;
    k = (idle_n - 1 >= d + 1) ? (idle_n - 1 - d - 1) / p + 1 : 0;
    if (md != 0) ef2 = f2_after(ef2, k);
    else         ep2 = (ep2 + k * c) % PM;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_out("in reset", 1, 1, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    chk_out("after reset", 1, 1, 0, 0, 0, 0);

    man(3, 2, 90);
    man(3, 2, 360);
    sweep(0, 4, 90, 28, 0);
    man(5, 10, 300);
    sweep(0, 1, 500, 3, 0);
    man(1, 254, 0);
    sweep(1, 2, 0, 12, 0);

    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    chk_out("start+stop", ef1, ef2, ep2, 0, 0, 0);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk_out("start+stop hold", ef1, ef2, ep2, 0, 0, 0);

    sweep(0, 0, 45, 9, 1);

    for (int r = 0; r < 6; r++) begin
      man(int'($urandom_range(63, 0)), int'($urandom_range(255, 0)), int'($urandom_range(511, 0)));
      sweep(int'($urandom_range(1, 0)), int'($urandom_range(5, 0)), int'($urandom_range(511, 0)),
            int'($urandom_range(20, 0)), int'($urandom_range(1, 0)));
    end

    start = 1'b1; mode = 1'b0; dwell = 16'd0; pstep = 9'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("resync before reset", 16'(DDS_rst), 16'd1);
    reset = 1'b1;
    #1;
    chk_out("async reset", 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_out("idle after reset", 1, 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
